mem0_stage: RTL and testbench
=============================

MEM0_STAGE -- requirements
Module: mem0_stage

Interface
REQ-001 The module SHALL have these parameters: ADDR_W, default 32, data address width; DATA_W, default 32, store/load data width (only 32 is supported).
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  the single clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- ex_over_i  in  1  EX stage has a result ready this cycle.
- flush_i  in  1  kill the instruction held in this stage.
- in_valid_i  in  1  the latched EX->MEM0 bus holds a real instruction.
- in_mem_en_i  in  1  the instruction is a load or store.
- in_we_i  in  1  1 = store, 0 = load.
- in_size_i  in  2  access size: 00 byte, 01 half, 10 word.
- in_addr_i  in  ADDR_W  effective address.
- in_wdata_i  in  DATA_W  store data, right-aligned.
- in_rd_i  in  5  destination register.
- in_result_i  in  32  ALU result to pass through.
- mem_allow_in_o  out  1  this stage can accept a new instruction; drives the EX->MEM0 register enable together with ex_over_i.
- mem1_allow_in_i  in  1  MEM1 stage can accept an instruction.
- mem0_over_o  out  1  this stage's result is valid for MEM1 this cycle.
- data_req_o  out  1  data-bus request.
- data_wr_o  out  1  data-bus write.
- data_size_o  out  2  data-bus size, equal to in_size_i.
- data_addr_o  out  ADDR_W  data-bus address, equal to in_addr_i.
- data_wstrb_o  out  4  data-bus byte strobes.
- data_wdata_o  out  DATA_W  data-bus lane-replicated store data.
- data_addr_ok_i  in  1  data bus accepted the request this cycle.
- out_rd_o  out  5  in_rd_i passed through.
- out_result_o  out  32  in_result_i passed through.
- out_is_load_o  out  1  instruction was a valid aligned load.
- out_ale_o  out  1  address-alignment exception.
- out_lane_o  out  2  in_addr_i[1:0], for MEM1 load extraction.

Function
REQ-003 The stage SHALL implement four states: IDLE (no live instruction), ACTIVE (live, not complete), DONE (complete, waiting for MEM1), CANCEL (flushed request still pending on the bus).
REQ-004 The stage SHALL define ld = ex_over_i && mem_allow_in_o; on ld the state SHALL become ACTIVE at the next edge, provided in_valid_i is 1 in the following cycle.
REQ-005 The stage SHALL assert ale = in_mem_en_i && ((size==01 && addr[0]) || (size==10 && addr[1:0]!=0)), combinationally, as out_ale_o.
REQ-006 In ACTIVE, data_req_o SHALL be in_mem_en_i && !ale; data_req_o SHALL be 0 in IDLE and DONE.
REQ-007 In ACTIVE, mem0_over_o SHALL be !in_mem_en_i || ale || data_addr_ok_i; in DONE, mem0_over_o SHALL be 1; otherwise mem0_over_o SHALL be 0.
REQ-008 In ACTIVE, when data_req_o && data_addr_ok_i && !mem1_allow_in_i, the next state SHALL be DONE, and no second request SHALL be issued.
REQ-009 When mem0_over_o && mem1_allow_in_i, the instruction SHALL leave: the next state SHALL be ACTIVE if ld occurs in the same cycle, otherwise IDLE.
REQ-010 mem_allow_in_o SHALL equal !flush_i && (IDLE || (mem0_over_o && mem1_allow_in_i)); it SHALL be 0 in CANCEL.
REQ-011 Strobes SHALL be: byte 0001<<lane; half 0011<<lane; word 1111; all zero when !in_we_i or in CANCEL.
REQ-012 Write data SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata; data_wr_o SHALL be in_we_i.
REQ-013 Flush handling SHALL be:
- ACTIVE with data_req_o=1 and data_addr_ok_i=0: next state CANCEL.
- ACTIVE otherwise, or DONE: next state IDLE.
- mem0_over_o SHALL be forced to 0 during flush.
REQ-014 In CANCEL, data_req_o SHALL stay 1 with the held address and zero strobes until data_addr_ok_i, after which the next state SHALL be IDLE.
REQ-015 out_is_load_o SHALL be in_mem_en_i && !in_we_i && !ale.

Reset
REQ-016 While rst_ni=0, the state SHALL be IDLE asynchronously; data_req_o=0, mem0_over_o=0, mem_allow_in_o=1 (when flush_i=0).
REQ-017 Reset asserted in CANCEL or ACTIVE SHALL drop data_req_o immediately, with no completion pending.

Verification
REQ-018 Word store, addr 0x1000, addr_ok on the 3rd cycle, mem1_allow_in_i=1 -> req held 3 cycles, wstrb 1111, over only in the 3rd cycle.
REQ-019 Byte store, addr 0x1003, wdata 0xAB -> wstrb 1000, wdata 0xABABABAB.
REQ-020 Half load, addr 0x1001 -> ale=1, req never asserted, over=1 in the first ACTIVE cycle.
REQ-021 addr_ok=1 with mem1_allow_in_i=0 for 2 cycles -> DONE, a single request, over held, allow_in=0; then allow=1 with ex_over=1 -> back-to-back ACTIVE.
REQ-022 Flush during a pending store request -> CANCEL, strobes 0000 until addr_ok, then IDLE and allow_in=1.
REQ-023 rst_ni low mid-request -> req=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mem0_stage.sv
// MEM0 pipeline stage: issues the data-bus request for loads/stores, detects
// misaligned accesses, builds byte strobes and lane-replicated store data, and
// hands the instruction to MEM1. A flushed request that the bus has not yet
// accepted is parked in a cancel state until the bus takes it.
module mem0_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ex_over_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic              in_mem_en_i,
  input  logic              in_we_i,
  input  logic [1:0]        in_size_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  input  logic [4:0]        in_rd_i,
  input  logic [31:0]       in_result_i,
  output logic              mem_allow_in_o,
  input  logic              mem1_allow_in_i,
  output logic              mem0_over_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  output logic [4:0]        out_rd_o,
  output logic [31:0]       out_result_o,
  output logic              out_is_load_o,
  output logic              out_ale_o,
  output logic [1:0]        out_lane_o
);

  typedef enum logic [1:0] {StIdle, StActive, StDone, StCancel} state_e;

  state_e state_q, state_d;

  logic ale;
  logic live;   // ACTIVE and the latched bus really holds an instruction
  logic empty;  // nothing live in the stage
  logic req;
  logic over;
  logic allow_in;
  logic ld;

  // Plain pass-through of the latched EX->MEM0 bus.
  assign data_wr_o     = in_we_i;
  assign data_size_o   = in_size_i;
  assign data_addr_o   = in_addr_i;
  assign out_rd_o      = in_rd_i;
  assign out_result_o  = in_result_i;
  assign out_lane_o    = in_addr_i[1:0];
  assign out_ale_o     = ale;
  assign out_is_load_o = in_mem_en_i && !in_we_i && !ale;

  // Handshake outputs and next-state decision.
  always_comb begin
    ale = in_mem_en_i && ((in_size_i == 2'b01 && in_addr_i[0]) ||
                          (in_size_i == 2'b10 && in_addr_i[1:0] != 2'b00));
    live  = (state_q == StActive) && in_valid_i;
    empty = (state_q == StIdle) || ((state_q == StActive) && !in_valid_i);

    req  = 1'b0;
    over = 1'b0;
    if (live) begin
      req  = in_mem_en_i && !ale;
      over = !in_mem_en_i || ale || data_addr_ok_i;
    end else if (state_q == StDone) begin
      over = 1'b1;
    end else if (state_q == StCancel) begin
      req = 1'b1;
    end
    if (flush_i) over = 1'b0;

    allow_in = !flush_i && (empty || (over && mem1_allow_in_i));
    ld       = ex_over_i && allow_in;

    state_d = state_q;
    if (empty) begin
      state_d = ld ? StActive : StIdle;
    end else begin
      case (state_q)
        StActive: begin
          if (flush_i) begin
            state_d = (req && !data_addr_ok_i) ? StCancel : StIdle;
          end else if (over && mem1_allow_in_i) begin
            state_d = ld ? StActive : StIdle;
          end else if (req && data_addr_ok_i) begin
            // Accepted by the bus but MEM1 is stalled: park without re-requesting.
            state_d = StDone;
          end
        end
        StDone: begin
          if (flush_i) begin
            state_d = StIdle;
          end else if (mem1_allow_in_i) begin
            state_d = ld ? StActive : StIdle;
          end
        end
        StCancel: begin
          if (data_addr_ok_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    data_req_o     = req;
    mem0_over_o    = over;
    mem_allow_in_o = allow_in;
  end

  // Byte strobes and lane-replicated write data.
  always_comb begin
    data_wstrb_o = 4'b0000;
    data_wdata_o = in_wdata_i;
    case (in_size_i)
      2'b00: begin
        data_wstrb_o = 4'b0001 << in_addr_i[1:0];
        data_wdata_o = {4{in_wdata_i[7:0]}};
      end
      2'b01: begin
        data_wstrb_o = 4'b0011 << in_addr_i[1:0];
        data_wdata_o = {2{in_wdata_i[15:0]}};
      end
      2'b10: data_wstrb_o = 4'b1111;
      default: data_wstrb_o = 4'b0000;
    endcase
    // A cancelled request must not modify memory when the bus finally takes it.
    if (!in_we_i || state_q == StCancel) data_wstrb_o = 4'b0000;
  end

  // State register, asynchronously forced to IDLE so a pending request drops at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

endmodule

// File: tb/tb_mem0_stage.sv
// Scoreboard bench for mem0_stage: stimulus pushes expected bus handshakes and
// retirements into queues; a monitor pops and compares them as the DUT presents them.
module tb_mem0_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_over, flush, in_valid, in_mem_en, in_we;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, in_result;
  logic [4:0]  in_rd;
  logic        allow_in, mem1_allow, over, req, wr, addr_ok;
  logic [1:0]  dsize, lane;
  logic [31:0] daddr, wdata_o, out_result;
  logic [3:0]  wstrb;
  logic [4:0]  out_rd;
  logic        is_load, ale;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        is_load;
    logic        ale;
  } ret_t;

  bus_t bus_q[$];
  ret_t ret_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem0_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ex_over_i      (ex_over),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_mem_en_i    (in_mem_en),
    .in_we_i        (in_we),
    .in_size_i      (in_size),
    .in_addr_i      (in_addr),
    .in_wdata_i     (in_wdata),
    .in_rd_i        (in_rd),
    .in_result_i    (in_result),
    .mem_allow_in_o (allow_in),
    .mem1_allow_in_i(mem1_allow),
    .mem0_over_o    (over),
    .data_req_o     (req),
    .data_wr_o      (wr),
    .data_size_o    (dsize),
    .data_addr_o    (daddr),
    .data_wstrb_o   (wstrb),
    .data_wdata_o   (wdata_o),
    .data_addr_ok_i (addr_ok),
    .out_rd_o       (out_rd),
    .out_result_o   (out_result),
    .out_is_load_o  (is_load),
    .out_ale_o      (ale),
    .out_lane_o     (lane)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every bus handshake and every retirement against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (req && addr_ok) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 64'd1, 64'd0);
        else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_wr", {63'd0, wr}, {63'd0, e.wr});
          chk("bus_addr", {32'd0, daddr}, {32'd0, e.addr});
          chk("bus_strb", {60'd0, wstrb}, {60'd0, e.strb});
          chk("bus_wdata", {32'd0, wdata_o}, {32'd0, e.wdata});
        end
      end
      if (over && mem1_allow) begin
        if (ret_q.size() == 0) chk("ret_unexpected", 64'd1, 64'd0);
        else begin
          ret_t r;
          r = ret_q.pop_front();
          chk("ret_rd", {59'd0, out_rd}, {59'd0, r.rd});
          chk("ret_result", {32'd0, out_result}, {32'd0, r.result});
          chk("ret_is_load", {63'd0, is_load}, {63'd0, r.is_load});
          chk("ret_ale", {63'd0, ale}, {63'd0, r.ale});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue ld from IDLE, then present the latched instruction in the ACTIVE cycle.
  task automatic launch(input logic mem_en, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] res);
    ex_over = 1'b1;
    step();
    ex_over   = 1'b0;
    in_valid  = 1'b1;
    in_mem_en = mem_en;
    in_we     = we;
    in_size   = size;
    in_addr   = addr;
    in_wdata  = wd;
    in_rd     = rd;
    in_result = res;
  endtask

  initial begin
    rst_n = 1'b0; ex_over = 0; flush = 0; in_valid = 0; in_mem_en = 0; in_we = 0;
    in_size = 0; in_addr = 0; in_wdata = 0; in_rd = 0; in_result = 0;
    mem1_allow = 1; addr_ok = 0;
    #3;
    chk("rst_req", {63'd0, req}, 64'd0);
    chk("rst_over", {63'd0, over}, 64'd0);
    chk("rst_allow", {63'd0, allow_in}, 64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Word store, addr_ok on 3rd cycle.
    launch(1, 1, 2'b10, 32'h1000, 32'h1234_5678, 5'd5, 32'h1000);
    bus_q.push_back('{wr: 1, addr: 32'h1000, strb: 4'hF, wdata: 32'h1234_5678});
    ret_q.push_back('{rd: 5'd5, result: 32'h1000, is_load: 0, ale: 0});
    for (int i = 0; i < 3; i++) begin
      addr_ok = (i == 2);
      #1;
      chk("sw_req", {63'd0, req}, 64'd1);
      chk("sw_over", {63'd0, over}, {63'd0, (i == 2)});
      chk("sw_strb", {60'd0, wstrb}, 64'hF);
      step();
    end
    addr_ok = 0; in_valid = 0;
    chk("sw_idle_req", {63'd0, req}, 64'd0);
    chk("sw_idle_allow", {63'd0, allow_in}, 64'd1);

    // Byte store at 0x1003.
    launch(1, 1, 2'b00, 32'h1003, 32'h0000_00AB, 5'd6, 32'h1003);
    addr_ok = 1;
    bus_q.push_back('{wr: 1, addr: 32'h1003, strb: 4'b1000, wdata: 32'hABAB_ABAB});
    ret_q.push_back('{rd: 5'd6, result: 32'h1003, is_load: 0, ale: 0});
    #1;
    chk("sb_strb", {60'd0, wstrb}, 64'b1000);
    chk("sb_lane", {62'd0, lane}, 64'd3);
    step();
    addr_ok = 0; in_valid = 0;

    // Misaligned half load at 0x1001.
    launch(1, 0, 2'b01, 32'h1001, 32'h0, 5'd7, 32'h1001);
    ret_q.push_back('{rd: 5'd7, result: 32'h1001, is_load: 0, ale: 1});
    #1;
    chk("lh_ale", {63'd0, ale}, 64'd1);
    chk("lh_req", {63'd0, req}, 64'd0);
    chk("lh_over", {63'd0, over}, 64'd1);
    step();
    in_valid = 0;

    // Half store at 0x2002 and aligned word load at 0x2004.
    launch(1, 1, 2'b01, 32'h2002, 32'h0000_BEEF, 5'd8, 32'h2002);
    addr_ok = 1;
    bus_q.push_back('{wr: 1, addr: 32'h2002, strb: 4'b1100, wdata: 32'hBEEF_BEEF});
    ret_q.push_back('{rd: 5'd8, result: 32'h2002, is_load: 0, ale: 0});
    step();
    addr_ok = 0; in_valid = 0;
    launch(1, 0, 2'b10, 32'h2004, 32'h0, 5'd9, 32'h2004);
    addr_ok = 1;
    bus_q.push_back('{wr: 0, addr: 32'h2004, strb: 4'b0000, wdata: 32'h0});
    ret_q.push_back('{rd: 5'd9, result: 32'h2004, is_load: 1, ale: 0});
    step();
    addr_ok = 0; in_valid = 0;

    // MEM1 stalled for 2 cycles, then back-to-back issue.
    launch(1, 0, 2'b10, 32'h3000, 32'h0, 5'd10, 32'h3000);
    mem1_allow = 0; addr_ok = 1;
    bus_q.push_back('{wr: 0, addr: 32'h3000, strb: 4'b0000, wdata: 32'h0});
    ret_q.push_back('{rd: 5'd10, result: 32'h3000, is_load: 1, ale: 0});
    #1;
    chk("stall_req1", {63'd0, req}, 64'd1);
    chk("stall_over1", {63'd0, over}, 64'd1);
    chk("stall_allow1", {63'd0, allow_in}, 64'd0);
    step();
    addr_ok = 0;
    #1;
    chk("done_req", {63'd0, req}, 64'd0);
    chk("done_over", {63'd0, over}, 64'd1);
    chk("done_allow", {63'd0, allow_in}, 64'd0);
    step();
    mem1_allow = 1; ex_over = 1;
    #1;
    chk("done_release_allow", {63'd0, allow_in}, 64'd1);
    step();
    ex_over = 0; in_mem_en = 0; in_we = 0; in_rd = 5'd11; in_result = 32'h77;
    ret_q.push_back('{rd: 5'd11, result: 32'h77, is_load: 0, ale: 0});
    #1;
    chk("b2b_over", {63'd0, over}, 64'd1);
    chk("b2b_req", {63'd0, req}, 64'd0);
    step();
    in_valid = 0;

    // Flush during pending store request.
    launch(1, 1, 2'b10, 32'h4000, 32'h0000_0055, 5'd12, 32'h4000);
    bus_q.push_back('{wr: 1, addr: 32'h4000, strb: 4'b0000, wdata: 32'h0000_0055});
    #1;
    chk("fl_req0", {63'd0, req}, 64'd1);
    step();
    flush = 1;
    #1;
    chk("fl_over", {63'd0, over}, 64'd0);
    chk("fl_allow", {63'd0, allow_in}, 64'd0);
    step();
    flush = 0;
    #1;
    chk("cancel_req", {63'd0, req}, 64'd1);
    chk("cancel_strb", {60'd0, wstrb}, 64'd0);
    chk("cancel_allow", {63'd0, allow_in}, 64'd0);
    chk("cancel_over", {63'd0, over}, 64'd0);
    step();
    addr_ok = 1;
    #1;
    chk("cancel_req2", {63'd0, req}, 64'd1);
    step();
    addr_ok = 0; in_valid = 0;
    chk("post_cancel_req", {63'd0, req}, 64'd0);
    chk("post_cancel_allow", {63'd0, allow_in}, 64'd1);

    // Asynchronous reset mid-request.
    launch(1, 1, 2'b10, 32'h5000, 32'h1, 5'd13, 32'h5000);
    #1;
    chk("ar_req_before", {63'd0, req}, 64'd1);
    rst_n = 0;
    #1;
    chk("ar_req_after", {63'd0, req}, 64'd0);
    chk("ar_over_after", {63'd0, over}, 64'd0);
    step();
    rst_n = 1; in_valid = 0;
    step();
    chk("ar_allow", {63'd0, allow_in}, 64'd1);

    step();
    chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
    chk("ret_q_empty", 64'(ret_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
